mem_st_ctrl: RTL and testbench
==============================

// Module: mem_st_ctrl
// PURPOSE
//  Store-access sequencer between the MEM-stage store path and the data-memory port.
//  - Accepts one store request: funct3, byte address, register data.
//  - Rotates data and builds the byte mask per word lane.
//  - Splits stores that cross a word boundary into two word beats.
//  - Holds each beat on a req/ack memory port and reports done or error to the pipeline stall logic.
// PARAMETERS
//  TIMEOUT  255  max cycles to wait for mem_ack per beat; 0 = never time out
// PORTS
//  clk          in   1    single clock, all state on rising edge
//  rst          in   1    synchronous reset, active-high
//  req_valid    in   1    store request present
//  req_ready    out  1    controller can accept a request (IDLE)
//  req_funct3   in   3    IR::store_funct3_t (sb/sh/sw)
//  req_addr     in   32   Global::size_t byte address
//  req_data     in   32   Global::size_t store data, LSB-aligned
//  mem_req      out  1    beat valid; held until mem_ack
//  mem_addr     out  32   word-aligned address, [1:0]=2'b00
//  mem_wdata    out  32   lane-rotated store data
//  mem_wmask    out  4    byte-lane write enables
//  mem_ack      in   1    beat accepted; sampled only while mem_req=1
//  st_done      out  1    1-cycle pulse: store fully written
//  st_err       out  1    1-cycle pulse: illegal funct3, misaligned (no split), or timeout
// BEHAVIOUR
//  Reset values: req_ready=1, mem_req=0, mem_addr/mem_wdata=0, mem_wmask=0, st_done=0, st_err=0, state=IDLE.
//  Accept condition: req_valid & req_ready.
//  Registered on accept:
//    sh = req_addr[1:0]
//    rot = req_data rotated left by 8*sh; identical for both beats
//    m = {4'b0, base} << sh  (8 bits); base: sw=1111, sh=0011, sb=0001
//    beat0: addr = {req_addr[31:2],2'b00}, mask = m[3:0]
//    beat1: addr = beat0 addr + 4 (32-bit wrap allowed), mask = m[7:4]
//  FSM:
//    IDLE -> BEAT0 on accept, legal funct3.
//    IDLE -> IDLE on accept, illegal funct3; st_err pulses next cycle; no memory access.
//    BEAT0: mem_req=1, beat0 fields.
//      mem_ack with m[7:4]!=0 -> BEAT1.
//      mem_ack with m[7:4]==0 -> IDLE, st_done pulses.
//    BEAT1: mem_req=1, beat1 fields; mem_ack -> IDLE, st_done pulses.
//  Timing and handshake:
//    - mem_req rises the cycle after accept.
//    - Minimum latency accept->st_done: 2 cycles (1 beat), 3 cycles (2 beats).
//    - A new request may be accepted in the same cycle st_done/st_err is high.
//    - mem_addr, mem_wdata and mem_wmask are stable while mem_req=1.
//    - mem_req drops the cycle after mem_ack.
//  Timeout:
//    - Wait counter clears at each beat start.
//    - If it reaches TIMEOUT without mem_ack: IDLE, st_err pulses, remaining beat dropped.
//    - A beat0 already written is not rolled back.
//  Reset mid-beat: immediate IDLE, mem_req=0 next edge, no done/err pulse.
//  st_done and st_err are never high together.
// CONFIGURATION
//  MEM_ST_SPLIT_EN defined:
//    - cross-word stores (m[7:4]!=0) run as two beats as above.
//  MEM_ST_SPLIT_EN undefined:
//    - cross-word stores issue no memory access and pulse st_err the cycle after accept.
//    - BEAT1 state and beat1 registers are not built.
//    - In-word unaligned stores (e.g. sb any addr, sh addr=01) remain legal.
// STRUCTURE
//  Shared package holds:
//    - state enum st_ctrl_state_t {IDLE, BEAT0, BEAT1}
//    - width constants
//    - base-mask lookup function by IR::store_funct3_t
//  Sub-module st_beat_gen (combinational): funct3/addr/data -> rot, m[7:0].
//  This module: FSM, beat registers, wait counter, pulses.
// TESTING
//  1 sw addr 0x100 data 0xAABBCCDD, ack after 1 cycle -> one beat
//    addr 0x100 wdata 0xAABBCCDD mask 1111; st_done 2 cycles after accept
//  2 sb addr 0x203 data 0x11 -> one beat
//    addr 0x200 mask 1000 wdata[31:24]=0x11; st_done
//  3 sw addr 0x101 data 0x44332211, SPLIT_EN -> two beats
//    beat0: addr 0x100 mask 1110 wdata 0x33221144
//    beat1: addr 0x104 mask 0001 wdata 0x33221144
//    st_done after second ack
//    without SPLIT_EN: no mem_req, st_err
//  4 funct3=3'b011 -> mem_req stays 0, st_err 1 cycle after accept, req_ready stays 1
//  5 TIMEOUT=4, mem_ack held 0 -> mem_req high 4 cycles, then st_err; back-to-back request accepted same cycle
//  6 rst asserted during BEAT1 -> next cycle mem_req=0, req_ready=1, no st_done; then a new sh addr 0x002 works
//    (addr 0x000 mask 1100)

Source files
------------

// File: rtl/mem_st_ctrl_pkg.sv
// Shared types and helpers for the store-access sequencer.
// Latency: n/a (types, constants and a combinational lookup only).
// Backpressure: n/a.
package mem_st_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } st_ctrl_state_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  // Byte-enable pattern for a word-aligned store of the given width; zero means illegal funct3.
  function automatic logic [MASK_W-1:0] base_mask(input logic [2:0] funct3);
    logic [MASK_W-1:0] m;
    case (funct3)
      F3_SB:   m = 4'b0001;
      F3_SH:   m = 4'b0011;
      F3_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_st_ctrl_st_beat_gen.sv
// Lane steering for one store: rotated data and the 8-bit two-word byte mask.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller samples the outputs when it accepts a request.
module st_beat_gen
  import mem_st_ctrl_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rot,
  output logic [7:0]        mask,
  output logic              legal
);

  // Rotate data into its byte lanes; the same word is reused for both beats of a split store.
  always_comb begin
    case (addr[1:0])
      2'd0:    rot = data;
      2'd1:    rot = {data[23:0], data[31:24]};
      2'd2:    rot = {data[15:0], data[31:16]};
      default: rot = {data[7:0],  data[31:8]};
    endcase
  end

  // Low nibble enables lanes of the addressed word, high nibble spills into the next word.
  always_comb begin
    mask  = {4'b0000, base_mask(funct3)} << addr[1:0];
    legal = |base_mask(funct3);
  end

endmodule

// File: rtl/mem_st_ctrl.sv
// Store-access sequencer: one store request -> one or two word beats on a req/ack memory port.
// Latency: accept -> st_done in 2 cycles (one beat) or 3 cycles (two beats) with immediate acks.
// Backpressure: req_ready only in IDLE; each beat held on mem_req until mem_ack or TIMEOUT cycles.
// Build option: define MEM_ST_SPLIT_EN to run cross-word stores as two beats; otherwise they error.
module mem_st_ctrl
  import mem_st_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_err
);

  // Counter spans 0..TIMEOUT-1 cycles of waiting within one beat.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  st_ctrl_state_t    state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef MEM_ST_SPLIT_EN
  logic [3:0]        mask1_q, mask1_d;
`endif

  logic [31:0] bg_rot;
  logic [7:0]  bg_mask;
  logic        bg_legal;
  logic        cross_blocked;
  logic        timed_out;

  st_beat_gen u_beat_gen (
    .funct3 (req_funct3),
    .addr   (req_addr),
    .data   (req_data),
    .rot    (bg_rot),
    .mask   (bg_mask),
    .legal  (bg_legal)
  );

  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = mask_q;
  assign st_done   = done_q;
  assign st_err    = err_q;

  // Next-state: accept/reject requests, advance beats on ack, abort a beat on timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MEM_ST_SPLIT_EN
    mask1_d       = mask1_q;
    cross_blocked = 1'b0;
`else
    cross_blocked = |bg_mask[7:4];
`endif
    timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!bg_legal || cross_blocked) begin
            err_d = 1'b1;
          end else begin
            state_d = BEAT0;
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = bg_rot;
            mask_d  = bg_mask[3:0];
            cnt_d   = '0;
`ifdef MEM_ST_SPLIT_EN
            mask1_d = bg_mask[7:4];
`endif
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
`ifdef MEM_ST_SPLIT_EN
          if (mask1_q != 4'b0000) begin
            state_d = BEAT1;
            addr_d  = addr_q + 32'd4;
            mask_d  = mask1_q;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef MEM_ST_SPLIT_EN
      BEAT1: begin
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and beat registers; reset drops any in-flight beat without a done/err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_ST_SPLIT_EN
      mask1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MEM_ST_SPLIT_EN
      mask1_q <= mask1_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_st_ctrl.sv
// Self-checking bench for mem_st_ctrl: directed table, multi-cycle corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_st_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic        st_done;
  logic        st_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_st_ctrl #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ack    (mem_ack),
    .st_done    (st_done),
    .st_err     (st_err)
  );

  typedef struct {
    int          nbeats;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  m0;
    logic [3:0]  m1;
    logic [31:0] wd;
    bit          done;
    bit          err;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          dly0;
    int          dly1;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] a1;
    logic [3:0]  m1;
    logic [31:0] wd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                               input int dly0, input int dly1, input int nb,
                               input logic [31:0] a0, input logic [3:0] m0,
                               input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] wd);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.data = data; v.dly0 = dly0; v.dly1 = dly1;
    v.nb = nb; v.a0 = a0; v.m0 = m0; v.a1 = a1; v.m1 = m1; v.wd = wd;
    return v;
  endfunction

  // Table entries list two-beat results; without splitting those become an immediate error.
  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    int nb;
    nb = v.nb;
`ifndef MEM_ST_SPLIT_EN
    if (nb == 2) nb = 0;
`endif
    e.nbeats = nb;
    e.a0 = v.a0; e.a1 = v.a1; e.m0 = v.m0; e.m1 = v.m1; e.wd = v.wd;
    e.done = (nb > 0);
    e.err  = (nb == 0);
    return e;
  endfunction

  // Reference: which bytes land in which word and lane, and how the beats end given ack delays.
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                 input int dly0, input int dly1);
    exp_t e;
    int size;
    int sh;
    int planned;
    int dly;
    logic [7:0] m;
    case (f3)
      3'b000:  size = 1;
      3'b001:  size = 2;
      3'b010:  size = 4;
      default: size = 0;
    endcase
    sh = int'(a[1:0]);
    e.a0 = a & 32'hFFFF_FFFC;
    e.a1 = e.a0 + 32'd4;
    m = 8'h00;
    for (int i = 0; i < size; i++) m[sh + i] = 1'b1;
    e.m0 = m[3:0];
    e.m1 = m[7:4];
    e.wd = 32'h0;
    for (int k = 0; k < 4; k++) e.wd[8*k +: 8] = d[8*((k - sh + 4) % 4) +: 8];
    planned = (size == 0) ? 0 : ((e.m1 != 4'h0) ? 2 : 1);
`ifndef MEM_ST_SPLIT_EN
    if (planned == 2) planned = 0;
`endif
    e.nbeats = 0;
    e.done = 1'b0;
    e.err = 1'b0;
    if (planned == 0) begin
      e.err = 1'b1;
    end else begin
      for (int b = 0; b < planned; b++) begin
        e.nbeats++;
        dly = (b == 0) ? dly0 : dly1;
        if (TMO != 0 && dly >= TMO) begin
          e.err = 1'b1;
          break;
        end
      end
      if (!e.err) e.done = 1'b1;
    end
    return e;
  endfunction

  // Issue one request at the current sample point and follow it to its done/err pulse.
  task automatic run_txn(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int dly0, input int dly1, input exp_t e);
    int dly;
    int hold;
    chk({nm, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_data = d;
    step();
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = $urandom; req_data = $urandom;
    for (int b = 0; b < e.nbeats; b++) begin
      dly  = (b == 0) ? dly0 : dly1;
      hold = (TMO != 0 && dly >= TMO) ? TMO : dly + 1;
      for (int c = 0; c < hold; c++) begin
        chk({nm, " mem_req"},   32'(mem_req),   32'd1);
        chk({nm, " mem_addr"},  mem_addr,        (b == 0) ? e.a0 : e.a1);
        chk({nm, " mem_wmask"}, 32'(mem_wmask), 32'((b == 0) ? e.m0 : e.m1));
        chk({nm, " mem_wdata"}, mem_wdata,       e.wd);
        chk({nm, " busy_ready"}, 32'(req_ready), 32'd0);
        chk({nm, " early_pulse"}, 32'({st_done, st_err}), 32'd0);
        mem_ack = (c == dly);
        step();
        mem_ack = 1'b0;
      end
    end
    chk({nm, " mem_req_end"}, 32'(mem_req),   32'd0);
    chk({nm, " st_done"},     32'(st_done),   32'(e.done));
    chk({nm, " st_err"},      32'(st_err),    32'(e.err));
    chk({nm, " ready_after"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[10];
  exp_t e;
  logic [2:0]  rf3;
  logic [31:0] ra, rd;
  int          rdl0, rdl1;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_data = 32'h0; mem_ack = 1'b0;

    tbl[0] = mkv(3'b010, 32'h0000_0100, 32'hAABB_CCDD, 0, 0, 1, 32'h100, 4'b1111, 32'h104, 4'b0000, 32'hAABB_CCDD);
    tbl[1] = mkv(3'b000, 32'h0000_0203, 32'h0000_0011, 1, 0, 1, 32'h200, 4'b1000, 32'h204, 4'b0000, 32'h1100_0000);
    tbl[2] = mkv(3'b010, 32'h0000_0101, 32'h4433_2211, 0, 2, 2, 32'h100, 4'b1110, 32'h104, 4'b0001, 32'h3322_1144);
    tbl[3] = mkv(3'b011, 32'h0000_0040, 32'h1234_5678, 0, 0, 0, 32'h040, 4'b0000, 32'h044, 4'b0000, 32'h0);
    tbl[4] = mkv(3'b001, 32'h0000_0001, 32'h0000_BEEF, 2, 0, 1, 32'h000, 4'b0110, 32'h004, 4'b0000, 32'h00BE_EF00);
    tbl[5] = mkv(3'b001, 32'h0000_0003, 32'h0000_1234, 0, 1, 2, 32'h000, 4'b1000, 32'h004, 4'b0001, 32'h3400_0012);
    tbl[6] = mkv(3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1, 3, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0000_0000, 4'b0011, 32'hF00D_CAFE);
    tbl[7] = mkv(3'b111, 32'h0000_0010, 32'h0000_0001, 0, 0, 0, 32'h010, 4'b0000, 32'h014, 4'b0000, 32'h0);
    tbl[8] = mkv(3'b000, 32'h0000_0000, 32'hFFFF_FF5A, 3, 0, 1, 32'h000, 4'b0001, 32'h004, 4'b0000, 32'hFFFF_FF5A);
    tbl[9] = mkv(3'b001, 32'h0000_0102, 32'h0000_55AA, 0, 0, 1, 32'h100, 4'b1100, 32'h104, 4'b0000, 32'h55AA_0000);

    repeat (3) step();
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset mem_req",   32'(mem_req),   32'd0);
    chk("reset mem_addr",  mem_addr,       32'd0);
    chk("reset mem_wdata", mem_wdata,      32'd0);
    chk("reset mem_wmask", 32'(mem_wmask), 32'd0);
    chk("reset pulses",    32'({st_done, st_err}), 32'd0);
    rst = 1'b0;
    step();

    // Directed table, back-to-back.
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].f3, tbl[i].addr, tbl[i].data, tbl[i].dly0, tbl[i].dly1,
              from_vec(tbl[i]));
    end

    // Timeout: ack never comes, mem_req held TMO cycles, then error; next request accepted on the err cycle.
    e.nbeats = 1; e.a0 = 32'h40; e.a1 = 32'h44; e.m0 = 4'b1111; e.m1 = 4'b0000;
    e.wd = 32'h0BAD_F00D; e.done = 1'b0; e.err = 1'b1;
    run_txn("timeout", 3'b010, 32'h40, 32'h0BAD_F00D, 100, 0, e);
    chk("timeout err_with_ready", 32'({st_err, req_ready}), 32'b11);
    run_txn("after_timeout", 3'b000, 32'h0000_0041, 32'h0000_0077, 0, 0,
            from_vec(mkv(3'b000, 32'h41, 32'h77, 0, 0, 1, 32'h40, 4'b0010, 32'h44, 4'b0000, 32'h0000_7700)));

    // Reset in the middle of a beat (second beat when splitting is built).
    step();
`ifdef MEM_ST_SPLIT_EN
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0102; req_data = 32'h1122_3344;
    step();
    req_valid = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rst_mid in_beat1", 32'(mem_req), 32'd1);
    chk("rst_mid beat1_addr", mem_addr, 32'h104);
`else
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0100; req_data = 32'h1122_3344;
    step();
    req_valid = 1'b0;
    chk("rst_mid in_beat0", 32'(mem_req), 32'd1);
    chk("rst_mid beat0_addr", mem_addr, 32'h100);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid mem_req",   32'(mem_req),   32'd0);
    chk("rst_mid req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid pulses",    32'({st_done, st_err}), 32'd0);
    step();
    chk("rst_mid no_late_pulse", 32'({st_done, st_err}), 32'd0);
    run_txn("post_rst_sh", 3'b001, 32'h0000_0002, 32'h0000_ABCD, 0, 0,
            from_vec(mkv(3'b001, 32'h2, 32'hABCD, 0, 0, 1, 32'h0, 4'b1100, 32'h4, 4'b0000, 32'hABCD_0000)));

    // Random requests, ack delays, and idle gaps against the reference model.
    for (int n = 0; n < 200; n++) begin
      rf3  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      ra   = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      rd   = $urandom;
      rdl0 = $urandom_range(0, TMO + 1);
      rdl1 = $urandom_range(0, TMO + 1);
      run_txn($sformatf("rnd%0d", n), rf3, ra, rd, rdl0, rdl1, model(rf3, ra, rd, rdl0, rdl1));
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("rnd idle mem_req", 32'(mem_req), 32'd0);
        chk("rnd idle pulses",  32'({st_done, st_err}), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
